// File: rtl/ex_mem_pipe_stage_if.sv
// EX->MEM stage boundary bundle: flush, upstream and downstream valid/ready/data, occupancy.
// The debug pc/inst lanes exist only when PIPE_DBG_EN is defined.
interface ex_mem_pipe_stage_if #(
  parameter int DATA_W = 112,
  parameter int DBG_W  = 96
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
`ifdef PIPE_DBG_EN
  logic [DBG_W-1:0]  dbg_in;
  logic [DBG_W-1:0]  dbg_out;

  // Environment view: drives EX-side inputs and MEM-side ready.
  modport master (
    output flush, in_valid, in_data, out_ready, dbg_in,
    input  in_ready, out_valid, out_data, occ, dbg_out
  );

  // Stage view.
  modport slave (
    input  flush, in_valid, in_data, out_ready, dbg_in,
    output in_ready, out_valid, out_data, occ, dbg_out
  );
`else
  // Environment view: drives EX-side inputs and MEM-side ready.
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occ
  );

  // Stage view.
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occ
  );
`endif
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake and a one-entry skid buffer.
// in_ready depends on registered state only, so MEM back-pressure never reaches EX
// combinationally. Optional debug lanes (pc/inst) follow the payload when PIPE_DBG_EN is defined.
module ex_mem_pipe_stage #(
  parameter int              DATA_W    = 112,
  parameter int              DBG_W     = 96,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  ex_mem_pipe_stage_if.slave  bus
);

  logic              outValid;
  logic              skidValid;
  logic [DATA_W-1:0] mainData;
  logic [DATA_W-1:0] skidData;
  logic              inReady;
  logic              inFire;
  logic              mainLoad;

  // Handshake decode; mainLoad means the main register is empty or draining this cycle.
  always_comb begin
    inReady  = ~skidValid;
    inFire   = bus.in_valid & inReady;
    mainLoad = ~outValid | bus.out_ready;
  end

  // Occupancy flags: flush wins, then skid drains into main, else a stalled input goes to skid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
    end else if (bus.flush) begin
      outValid  <= 1'b0;
      skidValid <= 1'b0;
    end else if (mainLoad) begin
      outValid  <= skidValid | inFire;
      skidValid <= 1'b0;
    end else if (inFire) begin
      skidValid <= 1'b1;
    end
  end

  // Payload registers load only on a fire or skid->main move; flush leaves contents untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mainData <= RESET_VAL;
      skidData <= RESET_VAL;
    end else if (!bus.flush) begin
      if (mainLoad) begin
        if (skidValid) begin
          mainData <= skidData;
        end else if (inFire) begin
          mainData <= bus.in_data;
        end
      end else if (inFire) begin
        skidData <= bus.in_data;
      end
    end
  end

`ifdef PIPE_DBG_EN
  logic [DBG_W-1:0] mainDbg;
  logic [DBG_W-1:0] skidDbg;

  // Debug lanes share the payload's load conditions exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mainDbg <= '0;
      skidDbg <= '0;
    end else if (!bus.flush) begin
      if (mainLoad) begin
        if (skidValid) begin
          mainDbg <= skidDbg;
        end else if (inFire) begin
          mainDbg <= bus.dbg_in;
        end
      end else if (inFire) begin
        skidDbg <= bus.dbg_in;
      end
    end
  end

  // Drive debug output.
  always_comb begin
    bus.dbg_out = mainDbg;
  end
`endif

  // Outputs straight from registered state.
  always_comb begin
    bus.in_ready  = inReady;
    bus.out_valid = outValid;
    bus.out_data  = mainData;
    bus.occ       = {1'b0, outValid} + {1'b0, skidValid};
  end

  // The skid only fills behind a held main entry, so it can never be valid alone.
  skidImpliesMain: assert property (@(posedge clk) disable iff (!rst) !(skidValid && !outValid));

  // Widths must be meaningful even when the debug lanes are compiled out.
  paramSane: assert property (@(posedge clk) (DATA_W > 0) && (DBG_W > 0));

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage. The reference is a capacity-2 FIFO held as a queue:
// acceptance when fewer than 2 entries are held, head presented whenever non-empty, flush empties
// it and discards that cycle's input. Define PIPE_DBG_EN to also exercise the debug lanes.
module tb_ex_mem_pipe_stage;
  localparam int DATA_W = 112;
  localparam int DBG_W  = 96;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DBG_W-1:0]  dbg;
  } ent_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;
  ent_t modelQ[$];

  ex_mem_pipe_stage_if #(.DATA_W(DATA_W), .DBG_W(DBG_W)) bus ();

  ex_mem_pipe_stage #(.DATA_W(DATA_W), .DBG_W(DBG_W), .RESET_VAL('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f,
                       input logic [DBG_W-1:0] g);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    bus.flush     = f;
`ifdef PIPE_DBG_EN
    bus.dbg_in    = g;
`else
    if (g != '0) bus.in_data = d;  // debug value has nowhere to go in this build
`endif
  endtask

  // Monitor/scoreboard: compare outputs against the queue model, then advance the model.
  always @(negedge clk) begin
    int   cnt;
    logic inFire;
    logic outFire;
    ent_t e;
    if (!rst) begin
      modelQ.delete();
    end else begin
      cnt = modelQ.size();
      check("in_ready", {127'b0, bus.in_ready}, {127'b0, cnt < 2});
      check("out_valid", {127'b0, bus.out_valid}, {127'b0, cnt > 0});
      check("occ", {126'b0, bus.occ}, 128'(cnt));
      if (cnt > 0) begin
        check("out_data", 128'(bus.out_data), 128'(modelQ[0].data));
`ifdef PIPE_DBG_EN
        check("dbg_out", 128'(bus.dbg_out), 128'(modelQ[0].dbg));
`endif
      end
      inFire  = bus.in_valid && (cnt < 2);
      outFire = (cnt > 0) && bus.out_ready;
      if (bus.flush) begin
        modelQ.delete();
      end else begin
        if (outFire) void'(modelQ.pop_front());
        if (inFire) begin
          e.data = bus.in_data;
`ifdef PIPE_DBG_EN
          e.dbg = bus.dbg_in;
`else
          e.dbg = '0;
`endif
          modelQ.push_back(e);
          accepted++;
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic [DBG_W-1:0]  rg;
    int                cyc;
    int                target;
    bit                seen;

    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = DATA_W'(32'h99);
    bus.out_ready = 1'b1;
`ifdef PIPE_DBG_EN
    bus.dbg_in    = '0;
`endif

    // Reset with a payload offered: nothing may be captured.
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
    check("rst_in_ready", {127'b0, bus.in_ready}, 128'd1);
    check("rst_occ", {126'b0, bus.occ}, 128'd0);
    check("rst_out_data", 128'(bus.out_data), 128'd0);
`ifdef PIPE_DBG_EN
    check("rst_dbg_out", 128'(bus.dbg_out), 128'd0);
`endif
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b0;

    // Streaming: back-to-back 1..8, in_ready must stay high.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DATA_W'(i), 1'b1, 1'b0, '0);
      check("stream_in_ready", {127'b0, bus.in_ready}, 128'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    check("stream_last", 128'(bus.out_data), 128'h8);
    drive(1'b0, '0, 1'b1, 1'b0, '0);

    // Back-pressure: A accepted, then B stalls into the skid.
    drive(1'b1, DATA_W'(8'hA), 1'b1, 1'b0, '0);
    drive(1'b1, DATA_W'(8'hB), 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    check("bp_occ_full", {126'b0, bus.occ}, 128'd2);
    check("bp_in_ready", {127'b0, bus.in_ready}, 128'd0);
    check("bp_head", 128'(bus.out_data), 128'hA);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    check("bp_second", 128'(bus.out_data), 128'hB);
    check("bp_in_ready_back", {127'b0, bus.in_ready}, 128'd1);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    check("bp_drained", {126'b0, bus.occ}, 128'd0);

    // Flush while full with C offered: C must be discarded.
    drive(1'b1, DATA_W'(8'hD), 1'b0, 1'b0, '0);
    drive(1'b1, DATA_W'(8'hE), 1'b0, 1'b0, '0);
    drive(1'b1, DATA_W'(8'hC), 1'b0, 1'b1, '0);
    drive(1'b1, DATA_W'(8'hC), 1'b0, 1'b1, '0);
    check("flush_occ", {126'b0, bus.occ}, 128'd0);
    check("flush_out_valid", {127'b0, bus.out_valid}, 128'd0);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    check("flush_no_c", {127'b0, bus.out_valid}, 128'd0);

    // Asynchronous reset while an entry is held.
    drive(1'b1, DATA_W'(8'h77), 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    check("mid_occ_before", {126'b0, bus.occ}, 128'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {127'b0, bus.out_valid}, 128'd0);
    check("mid_rst_occ", {126'b0, bus.occ}, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

`ifdef PIPE_DBG_EN
    // Debug lanes ride with payload 0x5.
    drive(1'b1, DATA_W'(8'h5), 1'b1, 1'b0, {64'h80000004, 32'h00000013});
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    check("dbg_payload", 128'(bus.out_data), 128'h5);
    check("dbg_lane", 128'(bus.dbg_out), 128'({64'h80000004, 32'h00000013}));
    drive(1'b0, '0, 1'b1, 1'b0, '0);
`endif

    // Random valid/ready at 50%, with rare flushes.
    target = accepted + 1000;
    cyc    = 0;
    while (accepted < target && cyc < 20000) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      rg = {$urandom, $urandom, $urandom};
      drive(1'($urandom_range(0, 1)), rd, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0), rg);
      cyc++;
    end
    check("rand_budget", {127'b0, accepted >= target}, 128'd1);

    // Drain and confirm nothing is left behind.
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      if (modelQ.size() == 0) seen = 1'b1;
    end
    check("drain_model_empty", {127'b0, seen}, 128'd1);
    check("drain_occ", {126'b0, bus.occ}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
